// File: rtl/tt_um_koggestone_sub8.sv
// Two-operand 8-bit subtractor D = A - B built on a 3-level Kogge-Stone prefix adder (A + ~B + 1).
// Latency: B accepted at edge k -> difference, borrow, zero and a one-cycle valid_out at edge k+2.
// Backpressure: none; busy is high while computing (S1/S2) and valid_in is ignored then.
//
// Ports:
//   clk, rst_n     : clock and asynchronous active-low reset
//   ui_in[7:0]     : operand data (A when op_sel=0, B when op_sel=1)
//   uio_in[0]      : valid_in, uio_in[1] : op_sel, uio_in[7:2] unused
//   uo_out[7:0]    : registered difference
//   uio_out[7:4]   : {borrow, valid_out, zero, busy}, [3:0] tied low
//   uio_oe[7:0]    : constant 8'hF0 (upper nibble driven)
//   ena            : unused
// Build option: define KS_SUB_SAT_EN to clamp underflowing results to 0 (zero=1, borrow still 1).

module tt_um_koggestone_sub8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena
);

    typedef enum logic [1:0] {IDLE, HAVE_A, S1, S2} state_t;

    state_t     state, state_nxt;
    logic       valid_in, op_sel;
    logic       load_a, load_b, busy;
    logic [7:0] a_q, b_q;
    logic [7:0] p0_q, g1_q, p1_q;
    logic [7:0] diff_q;
    logic       borrow_q, zero_q, valid_q;

    assign valid_in = uio_in[0];
    assign op_sel   = uio_in[1];

    // Inputs that exist only for the harness pinout.
    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:2]};

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM next-state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_in && !op_sel) state_nxt = HAVE_A;
            HAVE_A:  if (valid_in &&  op_sel) state_nxt = S1;
            S1:      state_nxt = S2;
            S2:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM outputs ----------------
    always_comb begin
        load_a = 1'b0;
        load_b = 1'b0;
        busy   = 1'b0;
        case (state)
            IDLE:    load_a = valid_in && !op_sel;
            HAVE_A: begin
                load_a = valid_in && !op_sel;   // a fresh A replaces the held one
                load_b = valid_in &&  op_sel;
            end
            S1, S2:  busy = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Stage 1: generate/propagate and prefix level 1 ----------------
    logic [7:0] nb, g0, p0, g0c, g1, p1;
    always_comb begin
        nb  = ~b_q;
        g0  = a_q & nb;
        p0  = a_q ^ nb;
        // Carry-in of 1 is folded into bit 0's generate, so every later prefix
        // level can shift in zeros.
        g0c = {g0[7:1], g0[0] | p0[0]};
        g1  = g0c | (p0 & {g0c[6:0], 1'b0});
        p1  = p0  & {p0[6:0], 1'b1};
    end

    // ---------------- Stage 2: prefix levels 2-3 and sum ----------------
    logic [7:0] g2, p2, g3, carry, sum, diff_nxt;
    logic       cout, zero_nxt;
    always_comb begin
        g2    = g1_q | (p1_q & {g1_q[5:0], 2'b00});
        p2    = p1_q & {p1_q[5:0], 2'b11};
        g3    = g2   | (p2   & {g2[3:0], 4'b0000});
        carry = {g3[6:0], 1'b1};
        sum   = p0_q ^ carry;
        cout  = g3[7];
`ifdef KS_SUB_SAT_EN
        diff_nxt = cout ? sum : 8'h00;      // no carry-out means A < B
`else
        diff_nxt = sum;
`endif
        zero_nxt = (diff_nxt == 8'h00);
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            p0_q     <= 8'h00;
            g1_q     <= 8'h00;
            p1_q     <= 8'h00;
            diff_q   <= 8'h00;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            if (load_a) a_q <= ui_in;
            if (load_b) b_q <= ui_in;
            if (state == S1) begin
                p0_q <= p0;
                g1_q <= g1;
                p1_q <= p1;
            end
            valid_q <= (state == S2);
            if (state == S2) begin
                diff_q   <= diff_nxt;
                borrow_q <= ~cout;
                zero_q   <= zero_nxt;
            end
        end
    end

    assign uo_out  = diff_q;
    assign uio_out = {borrow_q, valid_q, zero_q, busy, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_koggestone_sub8.sv
module tb_tt_um_koggestone_sub8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int total = 0;
    int bad   = 0;

    tt_um_koggestone_sub8 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (1'b1)
    );

    always #5 clk = ~clk;

    // ---------------- Behavioural model ----------------
    // Tracks "do we hold an A", and a countdown from B acceptance to the result.
    logic [7:0] m_a, m_d, m_res;
    logic       m_have, m_bor, m_z, m_v, m_rbor;
    int         m_pend;

    function automatic logic [7:0] expect_diff(input logic [7:0] a, input logic [7:0] b);
`ifdef KS_SUB_SAT_EN
        if (a < b) return 8'h00;
`endif
        return a - b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a = 0; m_d = 0; m_res = 0; m_have = 0;
            m_bor = 0; m_z = 0; m_v = 0; m_rbor = 0; m_pend = 0;
        end else begin
            m_v = 0;
            if (m_pend > 0) begin
                m_pend = m_pend - 1;
                if (m_pend == 0) begin
                    m_d = m_res; m_bor = m_rbor; m_z = (m_res == 0); m_v = 1;
                end
            end else if (uio_in[0] && !uio_in[1]) begin
                m_a = ui_in; m_have = 1;
            end else if (uio_in[0] && uio_in[1] && m_have) begin
                m_res  = expect_diff(m_a, ui_in);
                m_rbor = (m_a < ui_in);
                m_have = 0;
                m_pend = 2;
            end
        end
    end

    // ---------------- Per-cycle compare against the model ----------------
    always @(negedge clk) begin
        logic [7:0] exp_uio;
        exp_uio = {m_bor, m_v, m_z, (m_pend > 0), 4'b0000};
        total++;
        if (uo_out !== m_d || uio_out !== exp_uio || uio_oe !== 8'hF0) begin
            bad++;
            if (bad < 30)
                $display("FAIL model t=%0t uo_out=%h exp=%h uio_out=%h exp=%h uio_oe=%h exp=f0",
                         $time, uo_out, m_d, uio_out, exp_uio, uio_oe);
        end
    end

    // ---------------- Literal checks ----------------
    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Drive A then B on consecutive cycles and check the result timing and values.
    // hold=1 keeps valid_in high with junk data while the DUT is busy.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ex_d,
                         input logic ex_b, input logic ex_z, input logic hold, input string nm);
        @(posedge clk); #1; uio_in = 8'h01; ui_in = a;
        @(posedge clk); #1; uio_in = 8'h03; ui_in = b;
        @(posedge clk); #1;                                 // edge k: B accepted
        if (hold) begin uio_in = 8'h01; ui_in = ~b; end else uio_in = 8'h00;
        @(negedge clk);
        check({nm, "_s1_valid"}, {7'b0, uio_out[6]}, 8'h00);
        check({nm, "_s1_busy"},  {7'b0, uio_out[4]}, 8'h01);
        @(posedge clk); #1;
        if (hold) begin uio_in = 8'h03; ui_in = 8'h33; end
        @(negedge clk);
        check({nm, "_s2_valid"}, {7'b0, uio_out[6]}, 8'h00);
        check({nm, "_s2_busy"},  {7'b0, uio_out[4]}, 8'h01);
        @(posedge clk); #1; uio_in = 8'h00;                 // edge k+2: result
        @(negedge clk);
        check({nm, "_d"},      uo_out, ex_d);
        check({nm, "_flags"},  {4'b0, uio_out[7:4]}, {4'b0, ex_b, 1'b1, ex_z, 1'b0});
        @(negedge clk);
        check({nm, "_pulse_end"}, {7'b0, uio_out[6]}, 8'h00);
    endtask

    initial begin
        int pulses;
        logic [7:0] ra, rb;

        // Reset state
        #3;
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'hF0);
        @(posedge clk); #1; rst_n = 1'b1;

        do_op(8'h50, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0, "sub_50_20");
`ifdef KS_SUB_SAT_EN
        do_op(8'h10, 8'h20, 8'h00, 1'b1, 1'b1, 1'b0, "sub_10_20_sat");
        do_op(8'h00, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, "sub_00_ff_sat");
`else
        do_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0, "sub_10_20");
        do_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, "sub_00_ff");
`endif
        do_op(8'hA5, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, "sub_a5_a5");
        do_op(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, "sub_ff_00");
        do_op(8'h81, 8'h7F, 8'h02, 1'b0, 1'b0, 1'b1, "sub_hold");

        // B strobe in IDLE is ignored; A overwrite keeps only the last A.
        @(posedge clk); #1; uio_in = 8'h03; ui_in = 8'h55;
        @(posedge clk); #1; uio_in = 8'h01; ui_in = 8'h07;
        @(posedge clk); #1; uio_in = 8'h01; ui_in = 8'h09;
        @(posedge clk); #1; uio_in = 8'h03; ui_in = 8'h02;
        @(posedge clk); #1; uio_in = 8'h00;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (uio_out[6]) begin
                pulses++;
                check("overwrite_d", uo_out, 8'h07);
            end
        end
        check("overwrite_pulses", pulses[7:0], 8'd1);

        // Reset during S1: outputs clear at once, the operation is lost.
        @(posedge clk); #1; uio_in = 8'h01; ui_in = 8'h40;
        @(posedge clk); #1; uio_in = 8'h03; ui_in = 8'h01;
        @(posedge clk); #1; uio_in = 8'h00;
        #2; rst_n = 1'b0; #1;
        check("midreset_uo_out", uo_out, 8'h00);
        check("midreset_uio_out", uio_out, 8'h00);
        @(posedge clk); #1; rst_n = 1'b1;
        // B without a fresh A must not start an operation.
        @(posedge clk); #1; uio_in = 8'h03; ui_in = 8'h03;
        @(posedge clk); #1; uio_in = 8'h00;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (uio_out[6] || uio_out[4]) pulses++;
        end
        check("midreset_no_result", pulses[7:0], 8'd0);
        do_op(8'h40, 8'h01, 8'h3F, 1'b0, 1'b0, 1'b0, "after_reset");

        // Random regression
        for (int i = 0; i < 10000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            do_op(ra, rb, expect_diff(ra, rb), ra < rb, expect_diff(ra, rb) == 8'h00,
                  (i % 7) == 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tt_um_koggestone_sub8.md
TT_UM_KOGGESTONE_SUB8 -- requirements
Module: tt_um_koggestone_sub8

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL: ui_in  input  8  operand data bus (minuend or subtrahend, selected by uio_in[1]).
REQ-004 SHALL: uio_in  input  8  [0] valid_in, [1] op_sel (0 = minuend A, 1 = subtrahend B), [7:2] ignored.
REQ-005 SHALL: uo_out  output  8  registered difference D = A - B.
REQ-006 SHALL: uio_out  output  8  [7] borrow, [6] valid_out, [5] zero, [4] busy, [3:0] = 0.
REQ-007 SHALL: uio_oe  output  8  constant 8'b1111_0000.
REQ-008 SHALL: ena  input  1  ignored; driven by the harness, never assigned inside the block.

Function
REQ-009 SHALL: FSM states IDLE, HAVE_A, S1, S2, sampling valid_in level every cycle (no edge detect).
REQ-010 SHALL: IDLE: valid_in=1 with op_sel=0 captures ui_in into A and goes to HAVE_A; valid_in=1 with op_sel=1 is ignored and the FSM stays in IDLE.
REQ-011 SHALL: HAVE_A: valid_in=1 with op_sel=1 captures ui_in into B and goes to S1; valid_in=1 with op_sel=0 overwrites A and stays in HAVE_A.
REQ-012 SHALL: S1: register stage-1 Kogge-Stone terms of A + ~B + 1 (g=A&~B, p=A^~B, prefix level 1, carry-in 1) and go to S2.
REQ-013 SHALL: S2: complete prefix levels 2-3, register D, borrow = ~carry_out, zero = (D==0), pulse valid_out for exactly one cycle, then return to IDLE.
REQ-014 SHALL: Latency: B accepted at edge k, so uo_out, borrow and zero update and valid_out rises at edge k+2.
REQ-015 SHALL: valid_in in S1/S2 is ignored; busy=1 in S1 and S2, otherwise 0.
REQ-016 SHALL: uo_out, borrow and zero hold their last result until the next S2 update.
REQ-017 SHALL: Arithmetic is modulo 2^8; borrow=1 iff A < B unsigned.
REQ-018 SHALL: Next operation: A may be accepted in the cycle after valid_out (IDLE), giving a minimum of 4 cycles per result.

Reset
REQ-019 SHALL: rst_n=0 asynchronously forces FSM=IDLE, A=B=0, pipeline regs=0, uo_out=0, borrow=0, zero=0, valid_out=0, busy=0.
REQ-020 SHALL: Reset mid-operation (HAVE_A, S1, S2) discards the operation, produces no valid_out pulse, and requires A to be reloaded.
REQ-021 SHALL: After rst_n deasserts, the first rising edge may accept A.

Configuration
REQ-022 SHALL: Macro KS_SUB_SAT_EN defined: saturating mode, so when borrow=1, uo_out=8'h00 and zero=1, while borrow still reports 1.
REQ-023 SHALL: Macro KS_SUB_SAT_EN undefined: wrap-around modulo-256 result per REQ-017.

Verification
REQ-024 SHALL: A=0x50 then B=0x20 on consecutive cycles -> uo_out=0x30, borrow=0, zero=0, valid_out pulse at edge k+2 only.
REQ-025 SHALL: A=0x10, B=0x20 -> without KS_SUB_SAT_EN: uo_out=0xF0, borrow=1; with it: uo_out=0x00, zero=1, borrow=1.
REQ-026 SHALL: A=0xA5, B=0xA5 -> uo_out=0x00, zero=1, borrow=0; A=0x00, B=0xFF -> uo_out=0x01, borrow=1 (wrap mode).
REQ-027 SHALL: B strobe in IDLE, then A=0x07, A=0x09 (overwrite), B=0x02 -> uo_out=0x07, exactly one valid_out pulse.
REQ-028 SHALL: valid_in held high during S1/S2 with new data -> result unaffected, busy=1 for 2 cycles.
REQ-029 SHALL: rst_n pulsed low during S1 -> all outputs 0 asynchronously, no valid_out, FSM in IDLE.
REQ-030 SHALL: Random regression of 10k A/B pairs -> D == (A-B) mod 256 and borrow == (A<B), in both macro builds.
